// File: rtl/midori_sbox_compress.sv
// Masked Midori S-box compression stage: raw glitch-barrier register (A), then per-share XOR
// compression into a registered 3x3 share output (B). Define DBG_UNMASK_EN to add dbg_plain_o.
module midori_sbox_compress #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [26:0]      cf_i,
    input  logic             cf_valid_i,
    output logic             cf_ready_o,
    output logic [8:0]       share_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] xfer_cnt_o
`ifdef DBG_UNMASK_EN
    ,
    output logic [2:0]       dbg_plain_o
`endif
);

    // Handshake: a transfer on either side happens only on a cycle where valid && ready.
    // Once valid is high, data is held until the matching ready is seen.
    logic [26:0]      a_q;
    logic             va_q;
    logic [8:0]       b_q;
    logic             vb_q;
    logic [CNT_W-1:0] cnt_q;

    logic             ready_b;
    logic             cap_a;
    logic             move_ab;
    logic             xfer_out;
    logic [8:0]       comp;

    assign ready_b    = !vb_q || out_ready_i;
    assign cf_ready_o = !va_q || ready_b;
    assign cap_a      = cf_valid_i && cf_ready_o;
    assign move_ab    = va_q && ready_b;
    assign xfer_out   = vb_q && out_ready_i;

    // Each XOR reads exactly one registered 3-bit share group; groups never mix, so no
    // unmasked intermediate is formed.
    always_comb begin
        comp = '0;
        for (int j = 0; j < 3; j++) begin
            for (int s = 0; s < 3; s++) begin
                comp[3*s+j] = ^a_q[9*j+3*s +: 3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            va_q  <= 1'b0;
            b_q   <= '0;
            vb_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (cap_a) begin
                a_q <= cf_i;
            end
            va_q <= cap_a || (va_q && !ready_b);
            if (move_ab) begin
                b_q <= comp;
            end
            vb_q <= move_ab || (vb_q && !out_ready_i);
            if (xfer_out) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign share_o     = b_q;
    assign out_valid_o = vb_q;
    assign xfer_cnt_o  = cnt_q;

`ifdef DBG_UNMASK_EN
    // Recombines the three shares of each coordinate; lab use only.
    always_comb begin
        dbg_plain_o = '0;
        for (int j = 0; j < 3; j++) begin
            dbg_plain_o[j] = b_q[j] ^ b_q[3+j] ^ b_q[6+j];
        end
    end
`endif

endmodule

// File: tb/tb_midori_sbox_compress.sv
// Directed bench for midori_sbox_compress; a second instance with CNT_W=4 shares the stimulus.
module tb_midori_sbox_compress;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [26:0] cf;
    logic        cf_valid;
    logic        cf_ready;
    logic [8:0]  share;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] xfer_cnt;

    logic        cf_ready4;
    logic [8:0]  share4;
    logic        out_valid4;
    logic [3:0]  xfer_cnt4;
`ifdef DBG_UNMASK_EN
    logic [2:0]  dbg_plain;
    logic [2:0]  dbg_plain4;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    midori_sbox_compress #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cf_i        (cf),
        .cf_valid_i  (cf_valid),
        .cf_ready_o  (cf_ready),
        .share_o     (share),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .xfer_cnt_o  (xfer_cnt)
`ifdef DBG_UNMASK_EN
        , .dbg_plain_o (dbg_plain)
`endif
    );

    midori_sbox_compress #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cf_i        (cf),
        .cf_valid_i  (cf_valid),
        .cf_ready_o  (cf_ready4),
        .share_o     (share4),
        .out_valid_o (out_valid4),
        .out_ready_i (out_ready),
        .xfer_cnt_o  (xfer_cnt4)
`ifdef DBG_UNMASK_EN
        , .dbg_plain_o (dbg_plain4)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cf_valid  = 1'b0;
        cf        = '0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cf_valid = 1'b0; cf = '0; out_ready = 1'b0;
        step();
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid got %b want 0", out_valid);
        end
        tests_run++;
        if (share !== 9'h000) begin
            tests_failed++; $display("FAIL reset_share got %h want 000", share);
        end
        tests_run++;
        if (xfer_cnt !== 16'd0) begin
            tests_failed++; $display("FAIL reset_cnt got %0d want 0", xfer_cnt);
        end
        rst_n = 1'b1;
        step();
        tests_run++;
        if (cf_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready got %b want 1", cf_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        cf        = 27'h0000007;
        cf_valid  = 1'b1;
        step();                      // capture edge
        cf_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL single_early got %b want 0", out_valid);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || share !== 9'h001) begin
            tests_failed++;
            $display("FAIL single_out got v=%b s=%h want v=1 s=001", out_valid, share);
        end
        step();
        tests_run++;
        if (xfer_cnt !== 16'd1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_cnt got cnt=%0d v=%b want cnt=1 v=0", xfer_cnt, out_valid);
        end
        // Other group patterns: even-parity group and the top group.
        cf = 27'h0000003; cf_valid = 1'b1;
        step();
        cf = 27'h4000000;
        step();
        cf_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || share !== 9'h000) begin
            tests_failed++;
            $display("FAIL pattern_even got v=%b s=%h want v=1 s=000", out_valid, share);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || share !== 9'h100) begin
            tests_failed++;
            $display("FAIL pattern_top got v=%b s=%h want v=1 s=100", out_valid, share);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        cf        = 27'h1249249;
        for (int cyc = 0; cyc < 7; cyc++) begin
            cf_valid = (cyc < 4);
            step();
            tests_run++;
            if (cyc >= 1 && cyc <= 4) begin
                if (out_valid !== 1'b1 || share !== 9'h1FF) begin
                    tests_failed++;
                    $display("FAIL b2b_out[%0d] got v=%b s=%h want v=1 s=1ff", cyc, out_valid, share);
                end
            end else begin
                if (out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_idle[%0d] got v=%b want 0", cyc, out_valid);
                end
            end
        end
        tests_run++;
        if (xfer_cnt !== 16'd4) begin
            tests_failed++; $display("FAIL b2b_cnt got %0d want 4", xfer_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] exp;
        do_reset();
        exp_q.delete();
        out_ready = 1'b0;
        cf_valid  = 1'b1;
        cf = 27'h0000007; exp_q.push_back(9'h001);
        step();
        tests_run++;
        if (cf_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bp_ready2 got %b want 1", cf_ready);
        end
        cf = 27'h0000038; exp_q.push_back(9'h008);
        step();
        cf = 27'h01C0000; exp_q.push_back(9'h004);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (cf_ready !== 1'b0 || out_valid !== 1'b1 || share !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d] got rdy=%b v=%b s=%h want rdy=0 v=1 s=%h",
                         k, cf_ready, out_valid, share, exp_q[0]);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (cf_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bp_release_ready got %b want 1", cf_ready);
        end
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            tests_run++;
            if (out_valid !== 1'b1 || share !== exp) begin
                tests_failed++;
                $display("FAIL bp_drain[%0d] got v=%b s=%h want v=1 s=%h", k, out_valid, share, exp);
            end
            step();
            cf_valid = 1'b0;
        end
        tests_run++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'd3) begin
            tests_failed++;
            $display("FAIL bp_end got v=%b cnt=%0d want v=0 cnt=3", out_valid, xfer_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        cf = 27'h0000007; cf_valid = 1'b1;
        step();
        cf_valid = 1'b0;
        step();
        step();                      // one transfer counted
        out_ready = 1'b0;
        cf_valid  = 1'b1;
        cf = 27'h0000038;
        step();
        cf = 27'h01C0000;
        step();                      // both stages valid
        rst_n = 1'b0; cf_valid = 1'b0; out_ready = 1'b1;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL rstmid got v=%b cnt=%0d want v=0 cnt=0", out_valid, xfer_cnt);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++;
            if (out_valid !== 1'b0 || xfer_cnt !== 16'd0) begin
                tests_failed++;
                $display("FAIL rstmid_stale[%0d] got v=%b cnt=%0d want v=0 cnt=0", k, out_valid, xfer_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        cf        = 27'h0000038;
        cf_valid  = 1'b1;
        for (int k = 0; k < 17; k++) step();
        cf_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        tests_run++;
        if (xfer_cnt4 !== 4'd1) begin
            tests_failed++; $display("FAIL wrap_cnt4 got %0d want 1", xfer_cnt4);
        end
        tests_run++;
        if (xfer_cnt !== 16'd17) begin
            tests_failed++; $display("FAIL wrap_cnt16 got %0d want 17", xfer_cnt);
        end
    endtask

`ifdef DBG_UNMASK_EN
    task automatic test_dbg_unmask();
        logic [2:0] plain_q[$];
        logic [2:0] p;
        int         sent;
        do_reset();
        out_ready = 1'b1;
        sent      = 0;
        for (int cyc = 0; cyc < 1010; cyc++) begin
            if (out_valid) begin
                tests_run++;
                if (plain_q.size() == 0) begin
                    tests_failed++; $display("FAIL dbg_extra output with empty queue");
                end else begin
                    p = plain_q.pop_front();
                    if (dbg_plain !== p) begin
                        tests_failed++; $display("FAIL dbg_plain got %b want %b", dbg_plain, p);
                    end
                end
            end
            if (sent < 1000) begin
                cf = 27'($urandom);
                cf_valid = 1'b1;
                for (int j = 0; j < 3; j++) p[j] = ^cf[9*j +: 9];
                plain_q.push_back(p);
                sent++;
            end else begin
                cf_valid = 1'b0;
            end
            step();
        end
        tests_run++;
        if (plain_q.size() != 0) begin
            tests_failed++; $display("FAIL dbg_left got %0d pending want 0", plain_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wrap();
`ifdef DBG_UNMASK_EN
        test_dbg_unmask();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
